prefix_adder_pipe: RTL

//  Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor for the datapath ALU.

---
 rtl/prefix_adder_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe
//   Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake on
//   both sides. A register stage follows every PIPE_EVERY prefix levels; the
//   last stage always ends in the output register, so the latency is
//   LAT = ceil(log2(WIDTH)/PIPE_EVERY) cycles at one op per cycle.
//
//   Parameters: WIDTH (power of 2, 8..64), PIPE_EVERY (1..log2(WIDTH)).
//   Optional feature: define PREFIX_ADDER_SAT_EN to clamp the sum to the most
//   positive/negative value on signed overflow (ovf and cout stay raw).
//
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-low reset
//     in_valid / in_ready   input handshake (in_ready is combinational)
//     a, b, cin, sub        operands; sub=1 gives a-b (cin ignored)
//     out_valid / out_ready output handshake
//     sum, cout, ovf, zero  result, carry-out (no borrow for sub),
//                           signed overflow, sum==0
module prefix_adder_pipe #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

    logic adv;

    // Single global stall: every stage moves together or not at all.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Applies Kogge-Stone levels lo..hi-1 (span 2^k) and returns G or P.
    function automatic logic [WIDTH-1:0] ks_levels(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input int unsigned      lo,
        input int unsigned      hi,
        input logic             want_p
    );
        logic [WIDTH-1:0] g, p, gn, pn;
        g = g_in;
        p = p_in;
        for (int unsigned k = lo; k < hi; k++) begin
            gn = g;
            pn = p;
            for (int unsigned i = (1 << k); i < WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << k)]);
                pn[i] = p[i] & p[i - (1 << k)];
            end
            g = gn;
            p = pn;
        end
        return want_p ? p : g;
    endfunction

    // Stage 0: bitwise generate/propagate
    logic [WIDTH-1:0] bb, x0, g0, p0;
    logic             c0;

    always_comb begin
        bb = sub ? ~b : b;
        c0 = sub ? 1'b1 : cin;
        x0 = a ^ bb;
        g0 = a & bb;
        // Carry-in folded into bit 0 as the bit -1 generate; the combined
        // propagate of bit 0 is then zero, so G_prefix[i] is the carry out of bit i.
        g0[0] = g0[0] | (x0[0] & c0);
        p0    = x0;
        p0[0] = 1'b0;
    end

    // Intermediate register stages (none when LAT == 1)
    for (genvar s = 0; s < LAT - 1; s++) begin : stg
        logic [WIDTH-1:0] g_in, p_in, x_in;
        logic             c_in, a_in, b_in, v_in;
        logic [WIDTH-1:0] g_q, p_q, x_q;
        logic             c_q, a_q, b_q, v_q;

        if (s == 0) begin : src
            assign g_in = g0;
            assign p_in = p0;
            assign x_in = x0;
            assign c_in = c0;
            assign a_in = a[WIDTH-1];
            assign b_in = bb[WIDTH-1];
            assign v_in = in_valid;
        end else begin : src
            assign g_in = stg[s-1].g_q;
            assign p_in = stg[s-1].p_q;
            assign x_in = stg[s-1].x_q;
            assign c_in = stg[s-1].c_q;
            assign a_in = stg[s-1].a_q;
            assign b_in = stg[s-1].b_q;
            assign v_in = stg[s-1].v_q;
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                g_q <= ks_levels(g_in, p_in, s * PIPE_EVERY, (s + 1) * PIPE_EVERY, 1'b0);
                p_q <= ks_levels(g_in, p_in, s * PIPE_EVERY, (s + 1) * PIPE_EVERY, 1'b1);
                x_q <= x_in;
                c_q <= c_in;
                a_q <= a_in;
                b_q <= b_in;
            end
        end
    end

    // Final stage inputs
    logic [WIDTH-1:0] fg_in, fp_in, fx;
    logic             fc, fa, fb, fv;

    if (LAT == 1) begin : fin_src
        assign fg_in = g0;
        assign fp_in = p0;
        assign fx    = x0;
        assign fc    = c0;
        assign fa    = a[WIDTH-1];
        assign fb    = bb[WIDTH-1];
        assign fv    = in_valid;
    end else begin : fin_src
        assign fg_in = stg[LAT-2].g_q;
        assign fp_in = stg[LAT-2].p_q;
        assign fx    = stg[LAT-2].x_q;
        assign fc    = stg[LAT-2].c_q;
        assign fa    = stg[LAT-2].a_q;
        assign fb    = stg[LAT-2].b_q;
        assign fv    = stg[LAT-2].v_q;
    end

    logic [WIDTH-1:0] fg, raw_sum, res_sum;
    logic             res_cout, res_ovf;

    always_comb begin
        fg       = ks_levels(fg_in, fp_in, (LAT - 1) * PIPE_EVERY, LEVELS, 1'b0);
        raw_sum  = fx ^ {fg[WIDTH-2:0], fc};
        res_cout = fg[WIDTH-1];
        res_ovf  = (fa == fb) && (raw_sum[WIDTH-1] != fa);
`ifdef PREFIX_ADDER_SAT_EN
        if (res_ovf) begin
            res_sum = fa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_sum = raw_sum;
        end
`else
        res_sum = raw_sum;
`endif
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= fv;
            sum       <= res_sum;
            cout      <= res_cout;
            ovf       <= res_ovf;
            zero      <= (res_sum == '0);
        end
    end

endmodule
